icache_stream_param: RTL

//  Parametrised next-gen instruction cache between the core fetch port and the memory controller.
//  - Set-associative Loop store: LOOP_WAYS ways x NUM_SETS sets, round-robin victim per set.
//  - Fully associative Stream Buffer of STREAM_DEPTH blocks, filled by sequential prefetch on a miss.
//  - Memory handshake is non-abortable: a new miss during a fetch is queued, never cancels the request.

---
 rtl/icache_stream_param_if.sv | 24 ++
 rtl/icache_stream_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_stream_param_if.sv
// Core-fetch and memory-block handshake bundle for icache_stream_param.
// slave = cache side, master = core/memory environment side.
interface icache_stream_param_if;
  logic        icache_REN;
  logic [31:0] icache_addr;
  logic        icache_halt;
  logic        icache_hit;
  logic [31:0] icache_load;
  logic        imem_REN;
  logic [28:0] imem_block_addr;
  logic        imem_hit;
  logic [63:0] imem_load;
  logic        DUT_error;

  modport slave (
    input  icache_REN, icache_addr, icache_halt, imem_hit, imem_load,
    output icache_hit, icache_load, imem_REN, imem_block_addr, DUT_error
  );

  modport master (
    output icache_REN, icache_addr, icache_halt, imem_hit, imem_load,
    input  icache_hit, icache_load, imem_REN, imem_block_addr, DUT_error
  );
endinterface

// File: rtl/icache_stream_param.sv
// Instruction cache: set-associative Loop store plus a sequentially prefetched Stream Buffer.
// 0-cycle hit lookup; non-abortable memory fetch. Optional perf counters via ICACHE_PERF_CNT_EN.
module icache_stream_param #(
  parameter int NUM_SETS     = 8,
  parameter int LOOP_WAYS    = 2,
  parameter int STREAM_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  icache_stream_param_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);

  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = 29 - IDX;
  localparam int WW   = (LOOP_WAYS > 1) ? $clog2(LOOP_WAYS) : 1;
  localparam int CW   = $clog2(STREAM_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t state, state_n;

  logic [NUM_SETS-1:0][LOOP_WAYS-1:0] loop_valid;
  logic [TAGW-1:0] loop_tag  [NUM_SETS][LOOP_WAYS];
  logic [63:0]     loop_data [NUM_SETS][LOOP_WAYS];
  logic [WW-1:0]   victim    [NUM_SETS];

  logic [STREAM_DEPTH-1:0] sb_valid;
  logic [28:0]     sb_addr [STREAM_DEPTH];
  logic [63:0]     sb_data [STREAM_DEPTH];

  logic [28:0]   base, base_n;
  logic [CW-1:0] counter, counter_n;
  logic          pending, pending_n;
  logic [28:0]   pending_addr, pending_addr_n;
  logic          sb_clear, sb_wr;
  logic          err_q;

  logic [28:0]     blk;
  logic [IDX-1:0]  set_idx;
  logic [TAGW-1:0] tag;
  logic [28:0]     fetch_addr;
  logic [28:0]     win_off;

  logic          loop_hit, sb_hit;
  logic [WW-1:0] loop_way;
  logic [CW-1:0] sb_idx;
  logic [63:0]   hit_block;
  logic          lookup_hit, loop_fill, miss, covered, new_miss;

  assign blk        = bus.icache_addr[31:3];
  assign set_idx    = bus.icache_addr[2+IDX:3];
  assign tag        = bus.icache_addr[31:3+IDX];
  assign fetch_addr = base + 29'(counter);
  assign win_off    = blk - base;

  always_comb begin
    loop_hit = 1'b0;
    loop_way = '0;
    for (int w = LOOP_WAYS - 1; w >= 0; w--) begin
      if (loop_valid[set_idx][w] && loop_tag[set_idx][w] == tag) begin
        loop_hit = 1'b1;
        loop_way = WW'(w);
      end
    end
  end

  always_comb begin
    sb_hit = 1'b0;
    sb_idx = '0;
    for (int e = STREAM_DEPTH - 1; e >= 0; e--) begin
      if (sb_valid[e] && sb_addr[e] == blk) begin
        sb_hit = 1'b1;
        sb_idx = CW'(e);
      end
    end
  end

  assign hit_block  = loop_hit ? loop_data[set_idx][loop_way] : sb_data[sb_idx];
  assign lookup_hit = bus.icache_REN & (loop_hit | sb_hit);
  assign loop_fill  = bus.icache_REN & ~loop_hit & sb_hit;
  assign miss       = bus.icache_REN & ~loop_hit & ~sb_hit;
  // A miss already inside the running burst window will be served by the prefetch.
  assign covered    = (state == FETCH) && (win_off < 29'(STREAM_DEPTH));
  assign new_miss   = miss & ~covered;

  assign bus.icache_hit      = lookup_hit;
  assign bus.icache_load     = lookup_hit ? (bus.icache_addr[2] ? hit_block[63:32] : hit_block[31:0]) : 32'd0;
  assign bus.imem_REN        = (state == FETCH);
  assign bus.imem_block_addr = (state == FETCH) ? fetch_addr : 29'd0;
  assign bus.DUT_error       = err_q;

  always_comb begin
    state_n        = state;
    base_n         = base;
    counter_n      = counter;
    pending_n      = pending;
    pending_addr_n = pending_addr;
    sb_clear       = 1'b0;
    sb_wr          = 1'b0;
    case (state)
      IDLE: begin
        if (new_miss) begin
          state_n   = FETCH;
          base_n    = blk;
          counter_n = '0;
          sb_clear  = 1'b1;
        end
      end
      FETCH: begin
        if (new_miss) begin
          pending_n      = 1'b1;
          pending_addr_n = blk;
        end
        // The outstanding request always completes before any redirect.
        if (bus.imem_hit) begin
          sb_wr = 1'b1;
          if (pending_n) begin
            base_n    = pending_addr_n;
            counter_n = '0;
            pending_n = 1'b0;
            sb_clear  = 1'b1;
          end else if (counter == CW'(STREAM_DEPTH - 1)) begin
            state_n   = IDLE;
            counter_n = '0;
          end else begin
            counter_n = counter + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (bus.icache_halt) begin
      state_n   = HALT;
      pending_n = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      base         <= '0;
      counter      <= '0;
      pending      <= 1'b0;
      pending_addr <= '0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_n;
      base         <= base_n;
      counter      <= counter_n;
      pending      <= pending_n;
      pending_addr <= pending_addr_n;
      err_q        <= bus.imem_hit & ~bus.imem_REN;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb_valid   <= '0;
      loop_valid <= '0;
      for (int s = 0; s < NUM_SETS; s++) victim[s] <= '0;
    end else begin
      if (sb_clear) sb_valid <= '0;
      else if (sb_wr) sb_valid[counter] <= 1'b1;
      if (loop_fill) begin
        loop_valid[set_idx][victim[set_idx]] <= 1'b1;
        victim[set_idx] <= (LOOP_WAYS == 1) ? '0 : victim[set_idx] + WW'(1);
      end
    end
  end

  // Payload arrays carry no reset; the valid bits above gate them.
  always_ff @(posedge CLK) begin
    if (sb_wr) begin
      sb_addr[counter] <= fetch_addr;
      sb_data[counter] <= bus.imem_load;
    end
    if (loop_fill) begin
      loop_tag[set_idx][victim[set_idx]]  <= tag;
      loop_data[set_idx][victim[set_idx]] <= hit_block;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state != HALT && bus.icache_REN) begin
      if (lookup_hit && perf_hits != '1) perf_hits <= perf_hits + 32'd1;
      if (!lookup_hit && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule
